// File: rtl/sprite_blitter.sv
// Rectangular pixel copy engine: streams a WxH block from a synchronous ROM
// to the VGA plotter, one pixel per clock, with clipping and colour-0 transparency.
module sprite_blitter #(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120,
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned COLOUR_W = 3
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                copy_enable,
   input  logic [7:0]          x0,
   input  logic [6:0]          y0,
   input  logic [7:0]          width,
   input  logic [6:0]          height,
   input  logic [ADDR_W-1:0]   src_base,
   input  logic [7:0]          src_stride,
   input  logic                transparent_en,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_data,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                busy,
   output logic                finished
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t state, state_next;

   logic [7:0]        lat_x0;
   logic [6:0]        lat_y0;
   logic [7:0]        lat_w;
   logic [6:0]        lat_h;
   logic [7:0]        lat_stride;
   logic              lat_trans;
   logic [7:0]        col;
   logic [6:0]        row;
   logic [ADDR_W-1:0] row_base;
   logic              pix_valid;
   logic              pix_inb;

   logic              accept;
   logic              zero_size;
   logic              last_col;
   logic              last_pix;
   logic [8:0]        issue_x;
   logic [7:0]        issue_y;
   logic              issue_inb;

   assign zero_size = (width == 8'd0) || (height == 7'd0);
   assign last_col  = (col == lat_w - 8'd1);
   assign last_pix  = last_col && (row == lat_h - 7'd1);

   // Widened coordinates so overflow lands off-screen instead of wrapping.
   assign issue_x   = 9'(lat_x0) + 9'(col);
   assign issue_y   = 8'(lat_y0) + 8'(row);
   assign issue_inb = (issue_x < 9'(SCREEN_W)) && (issue_y < 8'(SCREEN_H));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (copy_enable) begin
               accept     = 1'b1;
               state_next = zero_size ? FLUSH : RUN;
            end
         end
         RUN:     if (last_pix) state_next = FLUSH;
         FLUSH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address generation, parameter latch and one-stage coordinate pipeline.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lat_x0     <= '0;
         lat_y0     <= '0;
         lat_w      <= '0;
         lat_h      <= '0;
         lat_stride <= '0;
         lat_trans  <= 1'b0;
         col        <= '0;
         row        <= '0;
         row_base   <= '0;
         rom_addr   <= '0;
         pix_valid  <= 1'b0;
         pix_inb    <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         busy       <= 1'b0;
         finished   <= 1'b0;
      end else begin
         busy      <= (state_next != IDLE);
         finished  <= (state_next == FLUSH);
         pix_valid <= (state == RUN);
         if (state == RUN) begin
            pix_inb <= issue_inb;
            vga_x   <= issue_x[7:0];
            vga_y   <= issue_y[6:0];
         end
         if (accept) begin
            lat_x0     <= x0;
            lat_y0     <= y0;
            lat_w      <= width;
            lat_h      <= height;
            lat_stride <= src_stride;
            lat_trans  <= transparent_en;
            col        <= '0;
            row        <= '0;
            row_base   <= src_base;
            if (!zero_size) rom_addr <= src_base;
         end else if (state == RUN) begin
            if (last_col) begin
               col <= '0;
               if (!last_pix) begin
                  row      <= row + 7'd1;
                  row_base <= row_base + ADDR_W'(lat_stride);
                  rom_addr <= row_base + ADDR_W'(lat_stride);
               end
            end else begin
               col      <= col + 8'd1;
               rom_addr <= rom_addr + ADDR_W'(1);
            end
         end
      end
   end

   // Plot strobe must see the ROM word of the same cycle for transparency.
   assign vga_colour = rom_data;
   assign vga_plot   = pix_valid && pix_inb && !(lat_trans && (rom_data == '0));

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Downstream copy engine driven by the game control FSM.
- When copy_enable is raised, it copies a rectangular block of pixels from the selected background/sprite ROM to the VGA adapter, one pixel per clock.
- It pulses finished when the block is done.
- Used for stage backgrounds, tiles, explosions, bombs, player sprites and HP icons. The datapath muxes position, size and source base per draw_* signal; this block is agnostic to what it draws.

Parameters:
- SCREEN_W, 160, visible width in pixels; x coordinates at or beyond this are clipped.
- SCREEN_H, 120, visible height in pixels; y coordinates at or beyond this are clipped.
- ADDR_W, 15, ROM address width.
- COLOUR_W, 3, pixel colour width.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- copy_enable  in  1  request; level-held by control while a draw state is active
- x0  in  8  destination top-left x
- y0  in  7  destination top-left y
- width  in  8  block width in pixels, 0..160
- height  in  7  block height in pixels, 0..120
- src_base  in  ADDR_W  ROM address of source pixel (0,0)
- src_stride  in  8  ROM words per source row
- transparent_en  in  1  when 1, colour 0 is not plotted
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  COLOUR_W  ROM read data; synchronous ROM with 1-cycle latency
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  COLOUR_W  plot colour, equal to rom_data
- vga_plot  out  1  plot strobe
- busy  out  1  job in progress
- finished  out  1  one-cycle done pulse

Behaviour:
- Reset (async, resetn=0): state IDLE. rom_addr=0, vga_x=0, vga_y=0, vga_plot=0, busy=0, finished=0, all internal counters 0. Outputs change immediately, without waiting for a clock edge, including when reset hits mid-job. The job is abandoned and is not resumed after reset.
- State IDLE: if copy_enable=1 at an edge, latch x0, y0, width, height, src_base, src_stride and transparent_en.
  - If width=0 or height=0, go to FLUSH.
  - Otherwise go to RUN.
- State RUN: each cycle issue one pixel in raster order, column fastest.
  - rom_addr = row_base + col, where row_base starts at src_base and adds src_stride at each row end. No multiplier. Addresses wrap modulo 2^ADDR_W.
  - Issued coordinates are (x0+col, y0+row), carried one pipeline stage alongside the ROM read.
  - After the last pixel (col=width-1, row=height-1), go to FLUSH.
- State FLUSH: one cycle, during which finished=1; then go to IDLE.
- Timing: cycle 0 is the acceptance edge.
  - Pixel k address is valid in cycle k+1.
  - Its vga_x/vga_y/vga_plot are valid in cycle k+2, aligned with rom_data.
  - finished is high in cycle W*H+1, the same cycle as the last plot.
  - Back in IDLE in cycle W*H+2.
- vga_plot = registered pixel-valid AND in-bounds (x<SCREEN_W and y<SCREEN_H, evaluated at full width before truncation) AND NOT (transparent_en AND rom_data==0). Clipped or transparent pixels still consume their cycle.
- busy=1 in RUN and FLUSH, 0 in IDLE.
- copy_enable is ignored while busy; deasserting it mid-job does not abort. Latched parameters are immune to input changes during the job.
- Back-to-back jobs: if copy_enable is still 1 in the IDLE cycle after FLUSH, a new job is accepted with the inputs present in that cycle. This lets the control FSM move DRAW_TILE to DRAW_EXPLOSION with new muxed parameters.
- Coordinate arithmetic uses 9-bit x and 8-bit y internally so that overflow is detected as out-of-bounds rather than wrapping on-screen.

Test Plan:
- 2x2 opaque copy, x0=10, y0=20, src_base=100, stride=160 → rom_addr 100, 101, 260, 261 in cycles 1-4. Plots at (10,20), (11,20), (10,21), (11,21) in cycles 2-5. finished=1 only in cycle 5; busy 1 in cycles 1-5.
- Transparency: 4x1 block, rom_data sequence 3, 0, 5, 0, transparent_en=1 → vga_plot pattern 1, 0, 1, 0. Repeat with transparent_en=0 → 1, 1, 1, 1.
- Clipping: x0=158, width=4, height=1 → four rom_addr issued; plots only at x=158 and 159; finished in cycle 5. Also y0=119, height=2 → second row is never plotted.
- Zero size: width=0, height=5 → no rom_addr advance and no plot; finished in cycle 1; IDLE in cycle 2.
- Back-to-back: copy_enable held high; parameters switched in the cycle after finished → second job accepted in that cycle. First rom_addr of job 2 appears two cycles after job 1's finished, with no extra finished pulse.
- Reset mid-job: resetn=0 during pixel 3 of an 8x8 copy → vga_plot, busy and finished go to 0 immediately. After release, IDLE with no further plots until a new copy_enable.
